// File: rtl/dcache_pkg.sv
// Shared types for the dcache port scheduler: the lane identifier and the held request layout.
package dcache_pkg;

    localparam int DEFAULT_DEPTH = 3;
    localparam int REQ_AW_MAX    = 32;

    typedef enum logic {
        LANE_A = 1'b0,
        LANE_B = 1'b1
    } lane_e;

    // The address is zero-extended to a fixed width so the range check sees every request bit.
    typedef struct packed {
        logic                  store;
        logic [REQ_AW_MAX-1:0] addr;
        logic [15:0]           data;
        logic [4:0]            wb_addr;
    } req_t;

endpackage

// File: rtl/dcache_port_scheduler_lane.sv
// Single-entry request hold register for one issue lane.
// The lane stays ready while it is empty or while its entry is leaving on this edge.
module lane_hold_reg
    import dcache_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    input  logic          store_i,
    input  logic [AW-1:0] addr_i,
    input  logic [15:0]   data_i,
    input  logic [4:0]    wb_addr_i,
    input  logic          grant_i,
    output logic          ready_o,
    output logic          capture_o,
    output logic          held_o,
    output req_t          req_o
);

    logic held_q, held_d;
    req_t req_q, req_d;

    always_comb begin
        ready_o   = !held_q || grant_i;
        capture_o = valid_i && ready_o;
        held_d    = held_q;
        req_d     = req_q;
        if (capture_o) begin
            held_d        = 1'b1;
            req_d.store   = store_i;
            req_d.addr    = REQ_AW_MAX'(addr_i);
            req_d.data    = data_i;
            req_d.wb_addr = wb_addr_i;
        end else if (grant_i) begin
            held_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q <= 1'b0;
            req_q  <= '0;
        end else begin
            held_q <= held_d;
            req_q  <= req_d;
        end
    end

    assign held_o = held_q;
    assign req_o  = req_q;

endmodule

// File: rtl/dcache_port_scheduler.sv
// Two-lane scheduler onto a single-ported synchronous data cache.
// Requests issue oldest first (A wins ties); load data is written back to the owning lane.
module dcache_port_scheduler
    import dcache_pkg::*;
#(
    parameter int  DEPTH = DEFAULT_DEPTH,
    parameter int  AW    = 16,
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic          reqValidA_i,
    input  logic          reqValidB_i,
    output logic          reqReadyA_o,
    output logic          reqReadyB_o,
    input  logic          reqStoreA_i,
    input  logic          reqStoreB_i,
    input  logic [AW-1:0] reqAddrA_i,
    input  logic [AW-1:0] reqAddrB_i,
    input  logic [15:0]   reqDataA_i,
    input  logic [15:0]   reqDataB_i,
    input  logic [4:0]    reqWbAddrA_i,
    input  logic [4:0]    reqWbAddrB_i,
    output logic          memEn_o,
    output logic          memWe_o,
    output logic [IW-1:0] memAddr_o,
    output logic [15:0]   memWData_o,
    input  logic [15:0]   memRData_i,
    output logic          wbEnableA_o,
    output logic          wbEnableB_o,
    output logic [4:0]    wbAddressA_o,
    output logic [4:0]    wbAddressB_o,
    output logic [15:0]   wbDataA_o,
    output logic [15:0]   wbDataB_o,
    output logic          addrErr_o
);

    logic  held_a, held_b, cap_a, cap_b, grant_a, grant_b, granted, in_range;
    req_t  req_a, req_b, sel;

    logic        b_older_q, b_older_d;
    logic        rd_pend_q, rd_pend_d;
    lane_e       rd_lane_q, rd_lane_d;
    logic [4:0]  rd_wb_addr_q, rd_wb_addr_d;
    logic        rd_err_q, rd_err_d;
    logic        wb_en_a_q, wb_en_a_d, wb_en_b_q, wb_en_b_d;
    logic [4:0]  wb_addr_a_q, wb_addr_a_d, wb_addr_b_q, wb_addr_b_d;
    logic [15:0] wb_data_a_q, wb_data_a_d, wb_data_b_q, wb_data_b_d, rd_data;

    lane_hold_reg #(.AW(AW)) u_lane_a (
        .clk(clock_i), .rst_n(reset_n_i), .valid_i(reqValidA_i), .store_i(reqStoreA_i),
        .addr_i(reqAddrA_i), .data_i(reqDataA_i), .wb_addr_i(reqWbAddrA_i), .grant_i(grant_a),
        .ready_o(reqReadyA_o), .capture_o(cap_a), .held_o(held_a), .req_o(req_a)
    );

    lane_hold_reg #(.AW(AW)) u_lane_b (
        .clk(clock_i), .rst_n(reset_n_i), .valid_i(reqValidB_i), .store_i(reqStoreB_i),
        .addr_i(reqAddrB_i), .data_i(reqDataB_i), .wb_addr_i(reqWbAddrB_i), .grant_i(grant_b),
        .ready_o(reqReadyB_o), .capture_o(cap_b), .held_o(held_b), .req_o(req_b)
    );

    always_comb begin
        grant_b  = held_b && (!held_a || b_older_q);
        grant_a  = held_a && !grant_b;
        granted  = grant_a || grant_b;
        sel      = grant_b ? req_b : req_a;
        in_range = sel.addr < REQ_AW_MAX'(DEPTH);

        memEn_o    = granted && in_range;
        memWe_o    = memEn_o && sel.store;
        memAddr_o  = sel.addr[IW-1:0];
        memWData_o = sel.data;
        addrErr_o  = granted && !in_range;

        // Age only matters while both lanes stay occupied past this edge.
        b_older_d = b_older_q;
        if (cap_a && cap_b) begin
            b_older_d = 1'b0;
        end else if (cap_a) begin
            b_older_d = held_b && !grant_b;
        end else if (cap_b) begin
            b_older_d = !(held_a && !grant_a);
        end

        rd_pend_d    = granted && !sel.store;
        rd_lane_d    = grant_b ? LANE_B : LANE_A;
        rd_wb_addr_d = sel.wb_addr;
        rd_err_d     = !in_range;

        rd_data     = rd_err_q ? 16'h0000 : memRData_i;
        wb_en_a_d   = rd_pend_q && (rd_lane_q == LANE_A);
        wb_en_b_d   = rd_pend_q && (rd_lane_q == LANE_B);
        wb_addr_a_d = wb_en_a_d ? rd_wb_addr_q : wb_addr_a_q;
        wb_data_a_d = wb_en_a_d ? rd_data : wb_data_a_q;
        wb_addr_b_d = wb_en_b_d ? rd_wb_addr_q : wb_addr_b_q;
        wb_data_b_d = wb_en_b_d ? rd_data : wb_data_b_q;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            b_older_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_lane_q    <= LANE_A;
            rd_wb_addr_q <= '0;
            rd_err_q     <= 1'b0;
            wb_en_a_q    <= 1'b0;
            wb_en_b_q    <= 1'b0;
            wb_addr_a_q  <= '0;
            wb_addr_b_q  <= '0;
            wb_data_a_q  <= '0;
            wb_data_b_q  <= '0;
        end else begin
            b_older_q    <= b_older_d;
            rd_pend_q    <= rd_pend_d;
            rd_lane_q    <= rd_lane_d;
            rd_wb_addr_q <= rd_wb_addr_d;
            rd_err_q     <= rd_err_d;
            wb_en_a_q    <= wb_en_a_d;
            wb_en_b_q    <= wb_en_b_d;
            wb_addr_a_q  <= wb_addr_a_d;
            wb_addr_b_q  <= wb_addr_b_d;
            wb_data_a_q  <= wb_data_a_d;
            wb_data_b_q  <= wb_data_b_d;
        end
    end

    assign wbEnableA_o  = wb_en_a_q;
    assign wbEnableB_o  = wb_en_b_q;
    assign wbAddressA_o = wb_addr_a_q;
    assign wbAddressB_o = wb_addr_b_q;
    assign wbDataA_o    = wb_data_a_q;
    assign wbDataB_o    = wb_data_b_q;

endmodule

// File: tb/tb_dcache_port_scheduler.sv
// Directed-vector bench for dcache_port_scheduler with a small synchronous cache model.
module tb_dcache_port_scheduler;

    logic        clock_i = 1'b0;
    logic        reset_n_i;
    logic        reqValidA_i, reqValidB_i, reqReadyA_o, reqReadyB_o;
    logic        reqStoreA_i, reqStoreB_i;
    logic [15:0] reqAddrA_i, reqAddrB_i, reqDataA_i, reqDataB_i;
    logic [4:0]  reqWbAddrA_i, reqWbAddrB_i;
    logic        memEn_o, memWe_o;
    logic [1:0]  memAddr_o;
    logic [15:0] memWData_o;
    logic [15:0] memRData_i;
    logic        wbEnableA_o, wbEnableB_o;
    logic [4:0]  wbAddressA_o, wbAddressB_o;
    logic [15:0] wbDataA_o, wbDataB_o;
    logic        addrErr_o;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:3];
    logic        pre_en;
    logic [1:0]  pre_addr;
    logic [15:0] pre_data;

    dcache_port_scheduler #(.DEPTH(3), .AW(16)) dut (
        .clock_i(clock_i), .reset_n_i(reset_n_i),
        .reqValidA_i(reqValidA_i), .reqValidB_i(reqValidB_i),
        .reqReadyA_o(reqReadyA_o), .reqReadyB_o(reqReadyB_o),
        .reqStoreA_i(reqStoreA_i), .reqStoreB_i(reqStoreB_i),
        .reqAddrA_i(reqAddrA_i), .reqAddrB_i(reqAddrB_i),
        .reqDataA_i(reqDataA_i), .reqDataB_i(reqDataB_i),
        .reqWbAddrA_i(reqWbAddrA_i), .reqWbAddrB_i(reqWbAddrB_i),
        .memEn_o(memEn_o), .memWe_o(memWe_o), .memAddr_o(memAddr_o),
        .memWData_o(memWData_o), .memRData_i(memRData_i),
        .wbEnableA_o(wbEnableA_o), .wbEnableB_o(wbEnableB_o),
        .wbAddressA_o(wbAddressA_o), .wbAddressB_o(wbAddressB_o),
        .wbDataA_o(wbDataA_o), .wbDataB_o(wbDataB_o),
        .addrErr_o(addrErr_o)
    );

    always #5 clock_i = ~clock_i;

    always @(posedge clock_i) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (memEn_o) begin
            if (memWe_o) mem[memAddr_o] <= memWData_o;
            else         memRData_i     <= mem[memAddr_o];
        end
    end

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic set_a(input logic v, input logic st, input logic [15:0] a,
                         input logic [15:0] d, input logic [4:0] wb);
        reqValidA_i = v; reqStoreA_i = st; reqAddrA_i = a; reqDataA_i = d; reqWbAddrA_i = wb;
    endtask

    task automatic set_b(input logic v, input logic st, input logic [15:0] a,
                         input logic [15:0] d, input logic [4:0] wb);
        reqValidB_i = v; reqStoreB_i = st; reqAddrB_i = a; reqDataB_i = d; reqWbAddrB_i = wb;
    endtask

    task automatic preload(input logic [1:0] a, input logic [15:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        memRData_i = 16'h0000;
        #2;
        checks++; if (reqReadyA_o !== 1'b1) begin failures++; $display("FAIL rst_readyA got=%b exp=1", reqReadyA_o); end
        checks++; if (reqReadyB_o !== 1'b1) begin failures++; $display("FAIL rst_readyB got=%b exp=1", reqReadyB_o); end
        checks++; if (memEn_o !== 1'b0) begin failures++; $display("FAIL rst_memEn got=%b exp=0", memEn_o); end
        checks++; if ({wbEnableA_o, wbEnableB_o, addrErr_o} !== 3'b000) begin failures++; $display("FAIL rst_pulses got=%b exp=000", {wbEnableA_o, wbEnableB_o, addrErr_o}); end
        checks++; if ({wbDataA_o, wbDataB_o} !== 32'h0) begin failures++; $display("FAIL rst_wbdata got=%h exp=0", {wbDataA_o, wbDataB_o}); end
        preload(2'd0, 16'h1111);
        preload(2'd1, 16'h00AB);
        preload(2'd2, 16'h5555);
        reset_n_i = 1'b1;
        step();
        $display("reset: done");
    endtask

    task automatic test_lane_a_load();
        set_a(1, 0, 16'd1, 16'h0, 5'd7);
        checks++; if (reqReadyA_o !== 1'b1) begin failures++; $display("FAIL a_load_ready got=%b exp=1", reqReadyA_o); end
        step();
        set_a(0, 0, 0, 0, 0);
        checks++; if ({memEn_o, memWe_o, memAddr_o} !== {1'b1, 1'b0, 2'd1}) begin failures++; $display("FAIL a_load_cmd got=%b exp=1001", {memEn_o, memWe_o, memAddr_o}); end
        step();
        checks++; if (wbEnableA_o !== 1'b0) begin failures++; $display("FAIL a_load_early_wb got=%b exp=0", wbEnableA_o); end
        step();
        checks++; if ({wbEnableA_o, wbAddressA_o, wbDataA_o} !== {1'b1, 5'd7, 16'h00AB}) begin failures++; $display("FAIL a_load_wb got=%b/%0d/%h exp=1/7/00ab", wbEnableA_o, wbAddressA_o, wbDataA_o); end
        step();
        checks++; if (wbEnableA_o !== 1'b0) begin failures++; $display("FAIL a_load_pulse_end got=%b exp=0", wbEnableA_o); end
        $display("lane_a_load: addr=1 wb=7");
    endtask

    task automatic test_same_edge();
        set_a(1, 1, 16'd2, 16'h1234, 5'd0);
        set_b(1, 0, 16'd2, 16'h0, 5'd3);
        step();
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        checks++; if ({memEn_o, memWe_o, memAddr_o, memWData_o} !== {1'b1, 1'b1, 2'd2, 16'h1234}) begin failures++; $display("FAIL same_edge_store got=%b/%b/%0d/%h exp=1/1/2/1234", memEn_o, memWe_o, memAddr_o, memWData_o); end
        checks++; if (reqReadyB_o !== 1'b0) begin failures++; $display("FAIL same_edge_readyB got=%b exp=0", reqReadyB_o); end
        step();
        checks++; if ({memEn_o, memWe_o, memAddr_o} !== {1'b1, 1'b0, 2'd2}) begin failures++; $display("FAIL same_edge_load got=%b exp=1010", {memEn_o, memWe_o, memAddr_o}); end
        step();
        checks++; if (wbEnableB_o !== 1'b0) begin failures++; $display("FAIL same_edge_early_wb got=%b exp=0", wbEnableB_o); end
        step();
        checks++; if ({wbEnableB_o, wbAddressB_o, wbDataB_o, wbEnableA_o} !== {1'b1, 5'd3, 16'h1234, 1'b0}) begin failures++; $display("FAIL same_edge_wbB got=%b/%0d/%h A=%b exp=1/3/1234 A=0", wbEnableB_o, wbAddressB_o, wbDataB_o, wbEnableA_o); end
        $display("same_edge: storeA->2 loadB<-2");
    endtask

    task automatic test_age();
        set_a(1, 0, 16'd0, 16'h0, 5'd1);
        set_b(1, 0, 16'd1, 16'h0, 5'd2);
        step();
        set_b(0, 0, 0, 0, 0);
        set_a(1, 0, 16'd2, 16'h0, 5'd4);
        checks++; if ({memAddr_o, reqReadyA_o, reqReadyB_o} !== {2'd0, 1'b1, 1'b0}) begin failures++; $display("FAIL age_first got=%b exp=0010", {memAddr_o, reqReadyA_o, reqReadyB_o}); end
        step();
        set_a(0, 0, 0, 0, 0);
        checks++; if ({memEn_o, memAddr_o, reqReadyA_o} !== {1'b1, 2'd1, 1'b0}) begin failures++; $display("FAIL age_b_older got=%b exp=1010", {memEn_o, memAddr_o, reqReadyA_o}); end
        step();
        checks++; if ({memAddr_o, wbEnableA_o, wbAddressA_o, wbDataA_o} !== {2'd2, 1'b1, 5'd1, 16'h1111}) begin failures++; $display("FAIL age_a1_wb got=%0d/%b/%0d/%h exp=2/1/1/1111", memAddr_o, wbEnableA_o, wbAddressA_o, wbDataA_o); end
        step();
        checks++; if ({wbEnableB_o, wbAddressB_o, wbDataB_o, wbEnableA_o} !== {1'b1, 5'd2, 16'h00AB, 1'b0}) begin failures++; $display("FAIL age_b_wb got=%b/%0d/%h A=%b exp=1/2/00ab A=0", wbEnableB_o, wbAddressB_o, wbDataB_o, wbEnableA_o); end
        step();
        checks++; if ({wbEnableA_o, wbAddressA_o, wbDataA_o} !== {1'b1, 5'd4, 16'h1234}) begin failures++; $display("FAIL age_a2_wb got=%b/%0d/%h exp=1/4/1234", wbEnableA_o, wbAddressA_o, wbDataA_o); end
        $display("age: B older than refilled A");
    endtask

    task automatic test_addr_err();
        set_a(1, 0, 16'd5, 16'h0, 5'd9);
        step();
        set_a(1, 1, 16'd5, 16'hFFFF, 5'd0);
        checks++; if ({memEn_o, addrErr_o} !== 2'b01) begin failures++; $display("FAIL err_load got=%b exp=01", {memEn_o, addrErr_o}); end
        step();
        set_a(1, 0, 16'd1, 16'h0, 5'd12);
        checks++; if ({memEn_o, addrErr_o} !== 2'b01) begin failures++; $display("FAIL err_store got=%b exp=01", {memEn_o, addrErr_o}); end
        step();
        set_a(0, 0, 0, 0, 0);
        checks++; if ({wbEnableA_o, wbAddressA_o, wbDataA_o} !== {1'b1, 5'd9, 16'h0000}) begin failures++; $display("FAIL err_wb got=%b/%0d/%h exp=1/9/0000", wbEnableA_o, wbAddressA_o, wbDataA_o); end
        checks++; if ({memEn_o, memWe_o, memAddr_o, addrErr_o} !== {1'b1, 1'b0, 2'd1, 1'b0}) begin failures++; $display("FAIL err_next_cmd got=%b exp=10010", {memEn_o, memWe_o, memAddr_o, addrErr_o}); end
        step();
        checks++; if (wbEnableA_o !== 1'b0) begin failures++; $display("FAIL err_store_wb got=%b exp=0", wbEnableA_o); end
        step();
        checks++; if ({wbEnableA_o, wbAddressA_o, wbDataA_o} !== {1'b1, 5'd12, 16'h00AB}) begin failures++; $display("FAIL err_cache_kept got=%b/%0d/%h exp=1/12/00ab", wbEnableA_o, wbAddressA_o, wbDataA_o); end
        $display("addr_err: load 5, store 5 dropped");
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [0:3];
        logic [15:0] exp_d [0:3];
        addrs = '{16'd0, 16'd1, 16'd2, 16'd0};
        exp_d = '{16'h1111, 16'h00AB, 16'h1234, 16'h1111};
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin
                set_a(1, 0, addrs[k], 16'h0, 5'(10 + k));
                checks++; if (reqReadyA_o !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", k, reqReadyA_o); end
            end else begin
                set_a(0, 0, 0, 0, 0);
            end
            if (k >= 3) begin
                checks++; if ({wbEnableA_o, wbAddressA_o, wbDataA_o} !== {1'b1, 5'(7 + k), exp_d[k-3]}) begin failures++; $display("FAIL b2b_wb[%0d] got=%b/%0d/%h exp=1/%0d/%h", k - 3, wbEnableA_o, wbAddressA_o, wbDataA_o, 7 + k, exp_d[k-3]); end
            end
            step();
        end
        checks++; if (wbEnableA_o !== 1'b0) begin failures++; $display("FAIL b2b_tail got=%b exp=0", wbEnableA_o); end
        $display("back_to_back: 4 loads on A");
    endtask

    task automatic test_reset_midflight();
        set_a(1, 0, 16'd0, 16'h0, 5'd1);
        set_b(1, 0, 16'd1, 16'h0, 5'd2);
        step();
        set_a(1, 0, 16'd2, 16'h0, 5'd4);
        set_b(0, 0, 0, 0, 0);
        step();
        set_a(0, 0, 0, 0, 0);
        reset_n_i = 1'b0;
        #1;
        checks++; if ({memEn_o, reqReadyA_o, reqReadyB_o, addrErr_o} !== 4'b0110) begin failures++; $display("FAIL midrst_comb got=%b exp=0110", {memEn_o, reqReadyA_o, reqReadyB_o, addrErr_o}); end
        checks++; if ({wbEnableA_o, wbEnableB_o, wbDataA_o, wbAddressA_o} !== 23'h0) begin failures++; $display("FAIL midrst_wb got=%b/%b/%h/%0d exp=0/0/0000/0", wbEnableA_o, wbEnableB_o, wbDataA_o, wbAddressA_o); end
        step();
        reset_n_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if ({wbEnableA_o, wbEnableB_o, memEn_o} !== 3'b000) begin failures++; $display("FAIL midrst_after[%0d] got=%b exp=000", k, {wbEnableA_o, wbEnableB_o, memEn_o}); end
        end
        $display("reset_midflight: flushed");
    endtask

    initial begin
        test_reset();
        test_lane_a_load();
        test_same_edge();
        test_age();
        test_addr_err();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
